// File: rtl/pscan_pkg.sv
// pscan_pkg: shared types and constants for the pattern scan coprocessor.
//   pscan_state_e : controller states
//   DEF_*         : default memory map (message bytes, pattern byte, results)
//   CNT_W         : match counter width
//   popcnt4       : population count of a 4-bit hit vector
package pscan_pkg;

  typedef enum logic [2:0] {
    IDLE, ARMED, LOAD, SCAN, WB0, WB1, WB2, DONE
  } pscan_state_e;

  localparam int DEF_STR_LEN  = 32;
  localparam int DEF_PAT_ADDR = 32;
  localparam int DEF_RES_ADDR = 33;
  localparam int DEF_AW       = 8;
  localparam int CNT_W        = 8;
  localparam int PAT_W        = 5;
  localparam int NUM_WIN      = 4;   // windows per byte, both in-byte and crossing

  function automatic logic [2:0] popcnt4(input logic [NUM_WIN-1:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/pscan_window_match.sv
// pscan_window_match: combinational 5-bit window compare for one byte step.
//   win12  in  12  {prev[3:0], cur[7:0]}
//   pat    in  5   pattern to match
//   first  in  1   current byte is byte 0 (no predecessor, suppress crossings)
//   in_cnt out 3   windows fully inside cur that match (0..4)
//   in_any out 1   at least one in-byte match
//   x_cnt  out 3   windows straddling prev/cur that match (0..4)
module pscan_window_match
  import pscan_pkg::*;
(
  input  logic [11:0]      win12,
  input  logic [PAT_W-1:0] pat,
  input  logic             first,
  output logic [2:0]       in_cnt,
  output logic             in_any,
  output logic [2:0]       x_cnt
);

  logic [NUM_WIN-1:0] in_hit;
  logic [NUM_WIN-1:0] x_hit;

  // lane g: in-byte window cur[g+4:g], crossing window win12[g+8:g+4]
  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    assign in_hit[g] = (win12[g +: PAT_W] == pat);
    assign x_hit[g]  = (win12[g + 4 +: PAT_W] == pat);
  end

  assign in_cnt = popcnt4(in_hit);
  assign in_any = |in_hit;
  assign x_cnt  = first ? 3'd0 : popcnt4(x_hit);

endmodule

// File: rtl/pattern_scan_unit.sv
// pattern_scan_unit: scans STR_LEN message bytes for a 5-bit pattern and
// writes three match counts back to data memory.
//   clk, reset   : clock, synchronous active-high reset
//   start        : level; high arms, falling edge launches, high mid-run aborts
//   done         : high once all results are written, until next start
//   mem_addr     : shared read/write address (registered)
//   mem_rdata    : asynchronous read data for mem_addr
//   mem_we       : one-cycle write strobe per result
//   mem_wdata    : write data, valid with mem_we
// Results: RES_ADDR+0 = in-byte matches, +1 = bytes with any in-byte match,
// +2 = all matches over the concatenated stream (in-byte + crossing).
module pattern_scan_unit
  import pscan_pkg::*;
#(
  parameter int STR_LEN  = DEF_STR_LEN,
  parameter int PAT_ADDR = DEF_PAT_ADDR,
  parameter int RES_ADDR = DEF_RES_ADDR,
  parameter int AW       = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata
);

  pscan_state_e     state, state_n;
  logic [AW-1:0]    idx, idx_n;
  logic [PAT_W-1:0] pat;
  logic [3:0]       prev_lo;   // only the low nibble of the previous byte feeds crossings
  logic [CNT_W-1:0] ctb, cto, cts;
  logic [CNT_W-1:0] ctb_sum, cto_sum, cts_sum;

  logic [2:0] in_cnt, x_cnt;
  logic       in_any;

  pscan_window_match u_match (
    .win12  ({prev_lo, mem_rdata}),
    .pat    (pat),
    .first  (idx == '0),
    .in_cnt (in_cnt),
    .in_any (in_any),
    .x_cnt  (x_cnt)
  );

  assign ctb_sum = ctb + CNT_W'(in_cnt);
  assign cto_sum = cto + CNT_W'(in_any);
  assign cts_sum = cts + CNT_W'(in_cnt) + CNT_W'(x_cnt);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE:  if (start) state_n = ARMED;
      ARMED: if (!start) state_n = LOAD;
      LOAD: begin
        state_n = start ? ARMED : SCAN;
        idx_n   = '0;
      end
      SCAN: begin
        idx_n = idx + 1'b1;
        if (start)                        state_n = ARMED;
        else if (idx == AW'(STR_LEN - 1)) state_n = WB0;
      end
      WB0:   state_n = start ? ARMED : WB1;
      WB1:   state_n = start ? ARMED : WB2;
      WB2:   state_n = start ? ARMED : DONE;
      DONE:  if (start) state_n = ARMED;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pat       <= '0;
      prev_lo   <= '0;
      ctb       <= '0;
      cto       <= '0;
      cts       <= '0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;

      // datapath: act on the byte presented in the current state
      if (state == LOAD && !start) begin
        pat     <= mem_rdata[7:3];
        prev_lo <= '0;
        ctb     <= '0;
        cto     <= '0;
        cts     <= '0;
      end
      if (state == SCAN && !start) begin
        prev_lo <= mem_rdata[3:0];
        ctb     <= ctb_sum;
        cto     <= cto_sum;
        cts     <= cts_sum;
      end

      // outputs are registered against the next state so the async read
      // data is valid for the whole cycle the state occupies
      mem_we <= 1'b0;
      done   <= (state_n == DONE);
      unique case (state_n)
        LOAD: mem_addr <= AW'(PAT_ADDR);
        SCAN: mem_addr <= idx_n;
        WB0: begin
          // last byte is still being consumed on this edge, use the sum
          mem_addr  <= AW'(RES_ADDR);
          mem_we    <= 1'b1;
          mem_wdata <= ctb_sum;
        end
        WB1: begin
          mem_addr  <= AW'(RES_ADDR + 1);
          mem_we    <= 1'b1;
          mem_wdata <= cto;
        end
        WB2: begin
          mem_addr  <= AW'(RES_ADDR + 2);
          mem_we    <= 1'b1;
          mem_wdata <= cts;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_unit.sv
module tb_pattern_scan_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;

  logic [7:0] mem [0:255];
  int         wr_cnt;
  logic [7:0] wr_addr [0:7];
  int         checks;
  int         errors;

  pattern_scan_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      if (wr_cnt < 8) wr_addr[wr_cnt] = mem_addr;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic load_mem(input logic [7:0] fill, input logic [4:0] p);
    for (int i = 0; i < 32; i++) mem[i] = fill;
    mem[32] = {p, 3'b000};
    mem[33] = 8'hAA;
    mem[34] = 8'hAA;
    mem[35] = 8'hAA;
    wr_cnt  = 0;
  endtask

  // raise start, drop it, then count clocks from the launching edge to done
  task automatic launch_and_wait(output int lat);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done, mem_we, mem_addr, mem_wdata} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b we=%b addr=%0d wdata=%0d, want all 0",
               done, mem_we, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_zeros();
    int lat;
    load_mem(8'h00, 5'b00000);
    launch_and_wait(lat);
    checks++;
    if (lat !== 36) begin errors++; $display("FAIL zeros_latency: got %0d, want 36", lat); end
    checks++;
    if ({mem[33], mem[34], mem[35]} !== {8'd128, 8'd32, 8'd252}) begin
      errors++;
      $display("FAIL zeros_results: got %0d %0d %0d, want 128 32 252", mem[33], mem[34], mem[35]);
    end
  endtask

  task automatic test_fives();
    int lat;
    load_mem(8'h55, 5'b10101);
    launch_and_wait(lat);
    checks++;
    if ({mem[33], mem[34], mem[35]} !== {8'd64, 8'd32, 8'd126}) begin
      errors++;
      $display("FAIL fives_results: got %0d %0d %0d, want 64 32 126", mem[33], mem[34], mem[35]);
    end
  endtask

  task automatic test_ones();
    int lat;
    load_mem(8'hFF, 5'b00000);
    launch_and_wait(lat);
    checks++;
    if ({mem[33], mem[34], mem[35]} !== 24'd0) begin
      errors++;
      $display("FAIL ones_results: got %0d %0d %0d, want 0 0 0", mem[33], mem[34], mem[35]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== 3) begin errors++; $display("FAIL ones_write_count: got %0d, want 3", wr_cnt); end
    checks++;
    if ({wr_addr[0], wr_addr[1], wr_addr[2]} !== {8'd33, 8'd34, 8'd35}) begin
      errors++;
      $display("FAIL ones_write_addrs: got %0d %0d %0d, want 33 34 35", wr_addr[0], wr_addr[1], wr_addr[2]);
    end
    checks++;
    if (mem_we !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ones_idle_done: got we=%b done=%b, want we=0 done=1", mem_we, done);
    end
  endtask

  task automatic test_cross();
    int lat;
    load_mem(8'h00, 5'b11111);
    mem[3] = 8'h03;
    mem[4] = 8'hE0;
    launch_and_wait(lat);
    checks++;
    if ({mem[33], mem[34], mem[35]} !== {8'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL cross_results: got %0d %0d %0d, want 0 0 1", mem[33], mem[34], mem[35]);
    end
  endtask

  task automatic test_abort_reset();
    int lat;
    load_mem(8'h55, 5'b10101);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);             // launching edge
    repeat (11) @(posedge clk); // now scanning index 10
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({done, mem_we, mem_addr} !== 10'd0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got done=%b we=%b addr=%0d, want 0 0 0", done, mem_we, mem_addr);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset_quiet: got writes=%0d done=%b, want 0 0", wr_cnt, done);
    end
    launch_and_wait(lat);
    checks++;
    if ({mem[33], mem[34], mem[35]} !== {8'd64, 8'd32, 8'd126}) begin
      errors++;
      $display("FAIL abort_reset_rescan: got %0d %0d %0d, want 64 32 126", mem[33], mem[34], mem[35]);
    end
  endtask

  task automatic test_abort_start();
    int lat;
    load_mem(8'h00, 5'b00000);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 start = 1'b1;            // abort mid-scan, keep armed
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== 0 || done !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_quiet: got writes=%0d done=%b we=%b, want 0 0 0", wr_cnt, done, mem_we);
    end
    launch_and_wait(lat);
    checks++;
    if (lat !== 36 || {mem[33], mem[34], mem[35]} !== {8'd128, 8'd32, 8'd252}) begin
      errors++;
      $display("FAIL abort_start_rescan: got lat=%0d res %0d %0d %0d, want 36 128 32 252",
               lat, mem[33], mem[34], mem[35]);
    end
  endtask

  task automatic test_done_restart();
    int lat;
    load_mem(8'h00, 5'b11111);
    mem[5] = 8'h1F;
    launch_and_wait(lat);
    checks++;
    if ({mem[33], mem[34], mem[35]} !== {8'd1, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL single_results: got %0d %0d %0d, want 1 1 1", mem[33], mem[34], mem[35]);
    end
    @(posedge clk);
    #1 start = 1'b1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_held: got %b, want 1", done); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear_on_start: got %b, want 0", done); end
    mem[33] = 8'hAA;
    mem[34] = 8'hAA;
    mem[35] = 8'hAA;
    launch_and_wait(lat);
    checks++;
    if (lat !== 36 || {mem[33], mem[34], mem[35]} !== {8'd1, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL restart_results: got lat=%0d res %0d %0d %0d, want 36 1 1 1",
               lat, mem[33], mem[34], mem[35]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    reset  = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) wr_addr[i] = 8'h00;
    test_reset();
    test_zeros();
    test_fives();
    test_ones();
    test_cross();
    test_abort_reset();
    test_abort_start();
    test_done_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_unit.md
Name: pattern_scan_unit

Overview:
Fixed-function coprocessor for the program-3 workload: 5-bit pattern search over the 32-byte message in data memory. Sits on the data memory port beside the CPU core. It reads the pattern byte and the 32 message bytes, computes three match counts, and writes them back to the result addresses. Uses the same start/done handshake as top_level, so the program-3 bench can target either implementation.

Parameters:
STR_LEN, 32, number of message bytes, at addresses 0..STR_LEN-1
PAT_ADDR, 32, address of the pattern byte; pattern = byte[7:3]
RES_ADDR, 33, first result address; results occupy RES_ADDR..RES_ADDR+2
AW, 8, data memory address width

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  level; held high to arm, falling edge launches the scan
done  out  1  registered; high when results are written, held until next start
mem_addr  out  AW  data memory address, shared by reads and writes
mem_rdata  in  8  data memory read data; asynchronous read (valid in the same cycle as mem_addr)
mem_we  out  1  one-cycle write strobe
mem_wdata  out  8  write data, valid with mem_we

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; done=0, mem_we=0, mem_addr=0, mem_wdata=0; all counters and byte history cleared. Reset overrides every other input in every state.
- States:
  - IDLE -> ARMED when start=1.
  - ARMED stays while start=1, -> LOAD when start=0 is sampled (edge E0).
  - LOAD: mem_addr=PAT_ADDR; at E1 latch pat=mem_rdata[7:3], clear counters, -> SCAN with index 0.
  - SCAN: mem_addr=index; each edge consumes one byte. After byte STR_LEN-1 is consumed (E33), -> WB0.
  - WB0/WB1/WB2: drive addr RES_ADDR+0/+1/+2 with ctb/cto/cts, mem_we=1. Writes land at E34/E35/E36.
  - DONE: done=1 from E36.
  - DONE -> ARMED when start=1; done clears on that same edge.
- start=1 sampled in LOAD, SCAN or WB*: abort, -> ARMED, mem_we=0, no further writes. Writes already committed are not undone.
- Per-byte arithmetic (cur = current byte, prev = previous byte, win12 = {prev[3:0], cur}):
  - In-byte matches: count of windows cur[4:0], cur[5:1], cur[6:2], cur[7:3] equal to pat (0..4). Add to ctb and to cts.
  - Any in-byte match: increment cto by 1.
  - Crossing matches (index>0 only): count of windows win12[11:7], [10:6], [9:5], [8:4] equal to pat (0..4). Add to cts only.
  - Byte 0 is the most significant byte of the concatenated stream. Total windows = 4 + 31*8 = 252.
- Widths: counters are 8-bit unsigned. Maxima: ctb 128, cto 32, cts 252, so no overflow is possible.
- mem_we is low in every state except WB*. mem_addr is don't-care-stable (hold last value) in IDLE/ARMED/DONE.
- Latency: done rises 36 clocks after E0.

Decomposition:
- pscan_pkg: state enum (IDLE, ARMED, LOAD, SCAN, WB0, WB1, WB2, DONE), default address constants, count width localparam.
- Sub-module pscan_window_match (combinational).
  - Inputs: win12, pat, first.
  - Outputs: in_cnt[2:0], in_any, x_cnt[2:0] (x_cnt forced to 0 when first=1).
- Top FSM, counters and memory mux stay in pattern_scan_unit.

Test Plan:
- All bytes 0x00, pat 00000 -> mem[33]=128, mem[34]=32, mem[35]=252; done 36 clocks after start falls.
- All bytes 0x55, pat 10101 -> 64, 32, 126.
- All bytes 0xFF, pat 00000 -> 0, 0, 0; exactly three mem_we pulses at addresses 33, 34, 35.
- All zero except byte3=0x03 and byte4=0xE0, pat 11111 -> 0, 0, 1 (crossing-only match is counted).
- Reset asserted for one cycle at SCAN index 10 -> IDLE, done=0, no writes. A new start pulse then yields correct results for the data loaded.
- Byte5=0x1F, rest 0x00, pat 11111 -> 1, 1, 1. Reassert start while in DONE -> done clears on that edge, rescan gives identical results.
